pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer: owns the architectural PC and decides each next PC
//  (sequential +4, branch target or jump target). Drives the instruction-memory
//  request/ack handshake and presents {PC, NPC, instruction} to decode with a
//  valid/ready handshake. Flushes wrong-path fetches on redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  ADDR_W    32             PC / address width
//  INSTR_W   32             instruction width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous, active-low reset
//  run            in   1        1 = keep fetching; 0 = stop after current instr
//  branch_taken   in   1        1-cycle redirect pulse from execute
//  branch_target  in   ADDR_W   target, valid while branch_taken=1
//  jump           in   1        1-cycle redirect pulse; priority over branch
//  jump_target    in   ADDR_W   target, valid while jump=1
//  imem_req       out  1        fetch request to instruction memory
//  imem_addr      out  ADDR_W   fetch address; stable while imem_req=1
//  imem_ack       in   1        memory returns imem_rdata this cycle
//  imem_rdata     in   INSTR_W  fetched instruction
//  if_valid       out  1        if_pc/if_npc/if_instr valid to decode
//  if_ready       in   1        decode accepts when if_valid&&if_ready
//  if_pc          out  ADDR_W   PC of delivered instruction
//  if_npc         out  ADDR_W   if_pc + 4
//  if_instr       out  INSTR_W  delivered instruction
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, kill=0, imem_req=0,
//    imem_addr=RESET_PC, if_valid=0, if_pc=0, if_npc=0, if_instr=0.
//  - Redirect = jump | branch_taken; target = jump ? jump_target : branch_target.
//  - FSM states IDLE, REQ, VALID; all outputs registered.
//  - IDLE: imem_req=0. run=1 -> REQ next cycle with imem_addr=pc.
//  - REQ: imem_req=1, imem_addr held until imem_ack sampled 1.
//    * ack, no kill, no redirect: if_instr<=imem_rdata, if_pc<=pc,
//      if_npc<=pc+4, pc<=pc+4, if_valid<=1, -> VALID.
//    * redirect without ack: pc<=target, kill<=1; stay REQ, addr unchanged.
//    * ack with kill or redirect: discard data, kill<=0, pc<=target (or
//      latched pc), stay REQ; imem_addr<=new pc next cycle (req stays 1).
//    * later redirect while kill=1 overwrites latched pc (newest wins).
//  - VALID: if_valid=1, outputs stable until handshake.
//    * if_ready=1, no redirect: if_valid<=0; run ? REQ(addr=pc) : IDLE.
//    * redirect (regardless of if_ready): flush, if_valid<=0, pc<=target,
//      -> REQ; delivered instruction counts as NOT consumed.
//  - IDLE + redirect: pc<=target, stay IDLE unless run=1.
//  - run=0 mid-REQ: outstanding fetch completes and delivers, then IDLE.
//  - Arithmetic: pc+4 mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  - Latency: 1 cycle REQ entry to ack min; if_valid the cycle after ack;
//    peak throughput 1 instr / 2 cycles.
//  - Targets used as-is (no alignment check). Reset mid-request abandons it;
//    a late imem_ack after reset while in IDLE is ignored.
// TESTING
//  1 Reset, run=1, ack every REQ cycle, rdata=pc^32'hA5A5_0000, if_ready=1
//    -> if_pc 0,4,8,C; if_npc 4,8,C,10; instr matches.
//  2 ack delayed 3 cycles -> imem_addr 32'h4 stable 3 cycles, if_valid
//    exactly 1 cycle after ack.
//  3 In REQ(addr 8) pulse branch_taken, target 32'h40, ack 2 cycles later ->
//    no if_valid for addr 8; next imem_addr=32'h40, if_pc=32'h40.
//  4 jump=1 (32'h100) and branch_taken=1 (32'h200) same cycle -> next fetch 100.
//  5 if_ready=0 for 4 cycles in VALID -> if_pc/if_instr stable, no new req;
//    redirect then -> if_valid drops, fetch at target.
//  6 RESET_PC=32'hFFFF_FFFC -> first if_npc=0, second fetch addr 0; rst_n
//    low mid-REQ -> imem_req=0, pc=RESET_PC immediately.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction-memory req/ack
// handshake and hands {pc, npc, instr} to decode, flushing wrong-path fetches.
module pc_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_npc,
  output logic [INSTR_W-1:0] if_instr
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               kill_q, kill_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ifv_q, ifv_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]  if_npc_q, if_npc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  assign pc_inc   = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ifv_d      = ifv_q;
    if_pc_d    = if_pc_q;
    if_npc_d   = if_npc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = target;
        if (run) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redirect ? target : pc_q;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (kill_q || redirect) begin
            // Wrong-path data: drop it and reissue at the newest PC without lowering req.
            kill_d = 1'b0;
            pc_d   = redirect ? target : pc_q;
            addr_d = redirect ? target : pc_q;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_npc_d   = pc_inc;
            pc_d       = pc_inc;
            ifv_d      = 1'b1;
            req_d      = 1'b0;
            state_d    = VALID;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      VALID: begin
        if (redirect) begin
          ifv_d   = 1'b0;
          pc_d    = target;
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = target;
        end else if (if_ready) begin
          ifv_d = 1'b0;
          if (run) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      ifv_q      <= 1'b0;
      if_pc_q    <= '0;
      if_npc_q   <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ifv_q      <= ifv_d;
      if_pc_q    <= if_pc_d;
      if_npc_q   <= if_npc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = ifv_q;
  assign if_pc     = if_pc_q;
  assign if_npc    = if_npc_q;
  assign if_instr  = if_instr_q;

endmodule
